// File: rtl/wb_reg_timeout.sv
// Registered Wishbone classic bridge with a slave watchdog; WB_REG_TIMEOUT_EN enables the watchdog.
// state  | meaning
// IDLE   | no slave strobe; wbs_cyc_o held while the master keeps its cycle (locked)
// ACTIVE | request on the slave port, waiting for a termination, abort or watchdog
// RESP   | one-cycle master termination with read data
module wb_reg_timeout #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP
  } state_t;

  state_t state;
  logic   slv_term;
  logic   wd_fire;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign slv_term = wbs_ack_i | wbs_err_i | wbs_rty_i;

`ifdef WB_REG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  // Down-counter loaded on entry to ACTIVE; terminal count 0 marks the last allowed wait cycle.
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign wd_fire   = (wd_cnt == '0);
  assign timeout_o = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_sel_o <= '0;
`ifdef WB_REG_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            wbs_we_o  <= wbm_we_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            state     <= ST_ACTIVE;
`ifdef WB_REG_TIMEOUT_EN
            wd_cnt    <= WD_LOAD;
`endif
          end else begin
            wbs_cyc_o <= wbs_cyc_o & wbm_cyc_i;
          end
        end

        ST_ACTIVE: begin
          // Abort beats a same-cycle slave response, which beats the watchdog.
          if (!wbm_cyc_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= ST_IDLE;
          end else if (slv_term) begin
            wbm_dat_o <= wbs_dat_i;
            wbm_ack_o <= wbs_ack_i;
            wbm_err_o <= wbs_err_i & ~wbs_ack_i;
            wbm_rty_o <= wbs_rty_i & ~wbs_ack_i & ~wbs_err_i;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= ST_RESP;
          end else if (wd_fire) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbm_err_o <= 1'b1;
`ifdef WB_REG_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
            state     <= ST_RESP;
          end else begin
`ifdef WB_REG_TIMEOUT_EN
            wd_cnt    <= wd_cnt - 1'b1;
`endif
          end
        end

        ST_RESP: begin
          wbm_ack_o <= 1'b0;
          wbm_err_o <= 1'b0;
          wbm_rty_o <= 1'b0;
          wbm_dat_o <= '0;
          wbs_cyc_o <= wbs_cyc_o & wbm_cyc_i;
`ifdef WB_REG_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Directed bench for wb_reg_timeout: vector table of single transfers plus abort, lock, reset and watchdog sequences.
module tb_wb_reg_timeout;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wbm_adr_i;
  logic [DW-1:0] wbm_dat_i;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [SW-1:0] wbm_sel_i;
  logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_i;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [SW-1:0] wbs_sel_o;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic          timeout_o;

  int total = 0;
  int bad   = 0;

  wb_reg_timeout #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    int            ws;
    logic          s_ack, s_err, s_rty;
    logic [DW-1:0] rdata;
    logic          e_ack, e_err, e_rty;
    logic [DW-1:0] e_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 64'(wbm_ack_o), 64'd0);
    chk({tag, "_err"}, 64'(wbm_err_o), 64'd0);
    chk({tag, "_rty"}, 64'(wbm_rty_o), 64'd0);
    chk({tag, "_mdat"}, 64'(wbm_dat_o), 64'd0);
    chk({tag, "_sstb"}, 64'(wbs_stb_o), 64'd0);
    chk({tag, "_swe"}, 64'(wbs_we_o), 64'd0);
    chk({tag, "_tmo"}, 64'(timeout_o), 64'd0);
  endtask

  task automatic clear_slave();
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    wbs_dat_i = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input logic lock, input string tag);
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    wbm_we_i  = v.we;
    wbm_adr_i = v.adr;
    wbm_dat_i = v.dat;
    wbm_sel_i = v.sel;
    for (int i = 0; i <= v.ws; i++) begin
      @(negedge clk);
      chk({tag, "_act_stb"}, 64'(wbs_stb_o), 64'd1);
      chk({tag, "_act_cyc"}, 64'(wbs_cyc_o), 64'd1);
      chk({tag, "_act_adr"}, 64'(wbs_adr_o), 64'(v.adr));
      chk({tag, "_act_wdat"}, 64'(wbs_dat_o), 64'(v.dat));
      chk({tag, "_act_sel"}, 64'(wbs_sel_o), 64'(v.sel));
      chk({tag, "_act_we"}, 64'(wbs_we_o), 64'(v.we));
      chk({tag, "_act_mterm"}, 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
      if (i == v.ws) begin
        wbs_ack_i = v.s_ack;
        wbs_err_i = v.s_err;
        wbs_rty_i = v.s_rty;
        wbs_dat_i = v.rdata;
      end
    end
    @(negedge clk);
    clear_slave();
    chk({tag, "_resp_ack"}, 64'(wbm_ack_o), 64'(v.e_ack));
    chk({tag, "_resp_err"}, 64'(wbm_err_o), 64'(v.e_err));
    chk({tag, "_resp_rty"}, 64'(wbm_rty_o), 64'(v.e_rty));
    chk({tag, "_resp_mdat"}, 64'(wbm_dat_o), 64'(v.e_dat));
    chk({tag, "_resp_sstb"}, 64'(wbs_stb_o), 64'd0);
    chk({tag, "_resp_cyc"}, 64'(wbs_cyc_o), 64'd1);
    @(negedge clk);
    chk_idle_outputs({tag, "_idle"});
    chk({tag, "_idle_cyc"}, 64'(wbs_cyc_o), 64'd1);
    wbm_stb_i = 1'b0;
    if (!lock) wbm_cyc_i = 1'b0;
    @(negedge clk);
    chk({tag, "_nodup_stb"}, 64'(wbs_stb_o), 64'd0);
    chk({tag, "_after_cyc"}, 64'(wbs_cyc_o), 64'(lock));
  endtask

  task automatic start_req(input logic we, input logic [AW-1:0] adr);
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    wbm_we_i  = we;
    wbm_adr_i = adr;
    wbm_dat_i = 32'hCAFE0000;
    wbm_sel_i = 4'hF;
  endtask

  initial begin
    vecs[0] = '{we:1'b0, adr:32'h100, dat:32'h0, sel:4'hF, ws:0,
                s_ack:1'b1, s_err:1'b0, s_rty:1'b0, rdata:32'hDEADBEEF,
                e_ack:1'b1, e_err:1'b0, e_rty:1'b0, e_dat:32'hDEADBEEF};
    vecs[1] = '{we:1'b1, adr:32'h200, dat:32'h12345678, sel:4'hC, ws:3,
                s_ack:1'b1, s_err:1'b0, s_rty:1'b0, rdata:32'hAAAA5555,
                e_ack:1'b1, e_err:1'b0, e_rty:1'b0, e_dat:32'hAAAA5555};
    vecs[2] = '{we:1'b0, adr:32'h304, dat:32'h0, sel:4'h3, ws:1,
                s_ack:1'b1, s_err:1'b1, s_rty:1'b1, rdata:32'h0BADF00D,
                e_ack:1'b1, e_err:1'b0, e_rty:1'b0, e_dat:32'h0BADF00D};
    vecs[3] = '{we:1'b0, adr:32'h408, dat:32'h0, sel:4'hF, ws:0,
                s_ack:1'b0, s_err:1'b1, s_rty:1'b1, rdata:32'h11112222,
                e_ack:1'b0, e_err:1'b1, e_rty:1'b0, e_dat:32'h11112222};
    vecs[4] = '{we:1'b0, adr:32'h50C, dat:32'h0, sel:4'h1, ws:2,
                s_ack:1'b0, s_err:1'b0, s_rty:1'b1, rdata:32'h33334444,
                e_ack:1'b0, e_err:1'b0, e_rty:1'b1, e_dat:32'h33334444};
    vecs[5] = '{we:1'b1, adr:32'h610, dat:32'hA5A5A5A5, sel:4'h6, ws:0,
                s_ack:1'b0, s_err:1'b1, s_rty:1'b0, rdata:32'h00000077,
                e_ack:1'b0, e_err:1'b1, e_rty:1'b0, e_dat:32'h00000077};

    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_stb_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_sel_i = '0;
    clear_slave();
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("reset_adr", 64'(wbs_adr_o), 64'd0);
    chk("reset_sel", 64'(wbs_sel_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Locked block: cycle held across two transfers, then released.
    run_txn(vecs[0], 1'b1, "lock0");
    run_txn(vecs[3], 1'b1, "lock1");
    wbm_cyc_i = 1'b0;
    @(negedge clk);
    chk("lock_release_cyc", 64'(wbs_cyc_o), 64'd0);

    // Master abort in the third ACTIVE cycle with a simultaneous slave ack.
    start_req(1'b1, 32'h700);
    repeat (2) begin
      @(negedge clk);
      chk("abort_pre_stb", 64'(wbs_stb_o), 64'd1);
    end
    @(negedge clk);
    chk("abort_pre_we", 64'(wbs_we_o), 64'd1);
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'h99998888;
    @(negedge clk);
    clear_slave();
    chk_idle_outputs("abort");
    chk("abort_cyc", 64'(wbs_cyc_o), 64'd0);
    @(negedge clk);
    chk("abort_later_ack", 64'(wbm_ack_o), 64'd0);
    chk("abort_later_mdat", 64'(wbm_dat_o), 64'd0);

    // Reset during ACTIVE with a same-cycle slave ack.
    start_req(1'b1, 32'h800);
    @(negedge clk);
    chk("rstmid_pre_stb", 64'(wbs_stb_o), 64'd1);
    rst = 1'b1;
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'h77776666;
    @(negedge clk);
    clear_slave();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    chk_idle_outputs("rstmid");
    chk("rstmid_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("rstmid_adr", 64'(wbs_adr_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_ack", 64'(wbm_ack_o), 64'd0);

    // Silent slave.
    begin
      int stb_cnt;
      logic fired;
      stb_cnt = 0;
      fired = 1'b0;
      start_req(1'b0, 32'h900);
`ifdef WB_REG_TIMEOUT_EN
      for (int c = 0; c < 4 * TO; c++) begin
        @(negedge clk);
        if (wbm_err_o) begin
          fired = 1'b1;
          break;
        end
        if (wbs_stb_o) stb_cnt++;
      end
      chk("wd_fired", 64'(fired), 64'd1);
      chk("wd_stb_cycles", 64'(stb_cnt), 64'(TO));
      chk("wd_timeout_pulse", 64'(timeout_o), 64'd1);
      chk("wd_ack", 64'(wbm_ack_o), 64'd0);
      chk("wd_cyc", 64'(wbs_cyc_o), 64'd0);
      chk("wd_stb", 64'(wbs_stb_o), 64'd0);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      @(negedge clk);
      chk("wd_err_clear", 64'(wbm_err_o), 64'd0);
      chk("wd_timeout_clear", 64'(timeout_o), 64'd0);
      wbs_ack_i = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("wd_late_ack", 64'(wbm_ack_o), 64'd0);
        chk("wd_late_cyc", 64'(wbs_cyc_o), 64'd0);
      end
      clear_slave();
`else
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (wbs_stb_o && !wbm_err_o && !timeout_o) stb_cnt++;
      end
      chk("nowd_stb_cycles", 64'(stb_cnt), 64'd1000);
      chk("nowd_err", 64'(wbm_err_o), 64'd0);
      chk("nowd_fired", 64'(fired), 64'd0);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      @(negedge clk);
      chk("nowd_abort_stb", 64'(wbs_stb_o), 64'd0);
      chk("nowd_abort_cyc", 64'(wbs_cyc_o), 64'd0);
      chk("nowd_abort_err", 64'(wbm_err_o), 64'd0);
`endif
    end

    // Bridge still usable after the watchdog/abort path.
    run_txn(vecs[1], 1'b0, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
